vend_ctrl: RTL and testbench

Transaction controller for the coin-operated vending machine. It accepts coins from the coin acceptor front end, accumulates credit, and handles a buy request. It drives the product dispenser and the change hopper through req/ack handshakes, and returns all remaining credit on cancel or idle timeout. It sits between the coin-sense logic and the two electromechanical actuators.

---
 rtl/vend_pkg.sv | 29 ++
 rtl/vend_if.sv | 38 +++
 rtl/vend_idle_timer.sv | 31 +++
 rtl/vend_ctrl.sv | 145 ++++++++++++++
 tb/tb_vend_ctrl.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/vend_pkg.sv
// vend_pkg: shared types and constants for the vending transaction controller.
// Holds the controller state encoding, the coin-acceptor codes and the
// rupee value of the smallest coin (the unit in which change is paid out).
package vend_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CREDIT = 2'd1,
        VEND   = 2'd2,
        CHANGE = 2'd3
    } vend_state_t;

    localparam logic [1:0] COIN_5    = 2'b00;
    localparam logic [1:0] COIN_10   = 2'b01;
    localparam logic [1:0] COIN_BAD  = 2'b10;
    localparam logic [1:0] COIN_NONE = 2'b11;

    localparam int COIN_UNIT = 5;

    // Rupee value of a coin code; bad / absent coins are worth nothing.
    function automatic int coin_value(input logic [1:0] code);
        case (code)
            COIN_5:  return COIN_UNIT;
            COIN_10: return 2 * COIN_UNIT;
            default: return 0;
        endcase
    endfunction

endpackage

// File: rtl/vend_if.sv
// vend_if: customer-side and actuator-side signals of the vending controller.
//
// Handshakes:
//   coin : a coin is taken on every rising clock edge where coin_valid and
//          coin_ready are both high; coin_ready depends on controller state only.
//   disp : disp_req is held high until the edge on which disp_ack (a
//          single-cycle pulse, only while disp_req is high) is sampled.
//   chg  : chg_req is held high for the whole payout; each sampled chg_ack
//          pays one 5rs coin, and acks may arrive on consecutive cycles.
//   buy / cancel are single-cycle requests; reject is a single-cycle pulse.
interface vend_if #(parameter int CW = 6);

    logic          coin_valid;
    logic [1:0]    coin;
    logic          coin_ready;
    logic          buy;
    logic          cancel;
    logic          reject;
    logic          disp_req;
    logic          disp_ack;
    logic          chg_req;
    logic          chg_ack;
    logic [CW-1:0] credit;
    logic          busy;

    // Environment side: coin acceptor, keypad and actuators.
    modport master (
        output coin_valid, coin, buy, cancel, disp_ack, chg_ack,
        input  coin_ready, reject, disp_req, chg_req, credit, busy
    );

    // Controller side.
    modport slave (
        input  coin_valid, coin, buy, cancel, disp_ack, chg_ack,
        output coin_ready, reject, disp_req, chg_req, credit, busy
    );

endinterface

// File: rtl/vend_idle_timer.sv
// vend_idle_timer: clear/enable up-counter with a terminal-count flag.
// tc is high during the TIMEOUT-th consecutive enabled, uncleared cycle,
// so the owner can act on the same edge the count would reach TIMEOUT.
module vend_idle_timer #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam int W = $clog2(TIMEOUT + 1);

    logic [W-1:0] cnt;

    // Count enabled idle cycles; clear has priority over counting.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tc = en && !clr && (cnt == W'(TIMEOUT - 1));

endmodule

// File: rtl/vend_ctrl.sv
// vend_ctrl: vending machine transaction controller.
// Collects coins into a credit register, vends on buy, and pays remaining
// credit back in 5rs coins through the change hopper.
// Optional feature: define VEND_TIMEOUT_EN to refund credit automatically
// after TIMEOUT idle cycles in CREDIT (uses vend_idle_timer).
module vend_ctrl
    import vend_pkg::*;
#(
    parameter int PRICE      = 15,
    parameter int MAX_CREDIT = 35,
    parameter int CW         = 6,
    parameter int TIMEOUT    = 255
) (
    input  logic        clk,
    input  logic        rst,
    vend_if.slave       bus,
    output vend_state_t dbg_state
);

    if ((PRICE % COIN_UNIT) != 0 || (MAX_CREDIT % COIN_UNIT) != 0 ||
        MAX_CREDIT < PRICE || MAX_CREDIT >= (1 << CW) || TIMEOUT < 1) begin : g_bad_cfg
        $error("vend_ctrl: inconsistent PRICE/MAX_CREDIT/CW/TIMEOUT");
    end

    vend_state_t   state_q, state_d;
    logic [CW-1:0] credit_q, credit_d;
    logic          reject_q, reject_d;

    logic          accepting;
    logic          coin_event;
    logic          coin_fits;
    logic [CW:0]   coin_sum;
    logic          timer_tc;

    assign accepting  = (state_q == IDLE) || (state_q == CREDIT);
    // Any taken coin other than "no coin" counts as a coin event (bad coins too).
    assign coin_event = bus.coin_valid && accepting && (bus.coin != COIN_NONE);
    assign coin_sum   = {1'b0, credit_q} + (CW+1)'(coin_value(bus.coin));
    assign coin_fits  = ((bus.coin == COIN_5) || (bus.coin == COIN_10)) &&
                        (coin_sum <= (CW+1)'(MAX_CREDIT));

`ifdef VEND_TIMEOUT_EN
    logic timer_clr;
    // Any customer activity, or being outside CREDIT, restarts the idle count.
    assign timer_clr = (state_q != CREDIT) || bus.cancel || coin_event || bus.buy;

    vend_idle_timer #(.TIMEOUT(TIMEOUT)) u_idle_timer (
        .clk (clk),
        .rst (rst),
        .clr (timer_clr),
        .en  (state_q == CREDIT),
        .tc  (timer_tc)
    );
`else
    assign timer_tc = 1'b0;
`endif

    // State, credit and reject registers; reset abandons any credit in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            credit_q <= '0;
            reject_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            credit_q <= credit_d;
            reject_q <= reject_d;
        end
    end

    // Next state and credit: in CREDIT, cancel beats a coin, which beats buy.
    always_comb begin
        state_d  = state_q;
        credit_d = credit_q;
        reject_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (coin_event) begin
                    if (coin_fits) begin
                        credit_d = coin_sum[CW-1:0];
                        state_d  = CREDIT;
                    end else begin
                        reject_d = 1'b1;
                    end
                end
            end
            CREDIT: begin
                if (bus.cancel) begin
                    state_d = CHANGE;
                end else if (coin_event) begin
                    if (coin_fits) begin
                        credit_d = coin_sum[CW-1:0];
                    end else begin
                        reject_d = 1'b1;
                    end
                end else if (bus.buy) begin
                    if (credit_q >= CW'(PRICE)) begin
                        state_d = VEND;
                    end
                end else if (timer_tc) begin
                    state_d = CHANGE;
                end
            end
            VEND: begin
                if (bus.disp_ack) begin
                    if (credit_q > CW'(PRICE)) begin
                        credit_d = credit_q - CW'(PRICE);
                        state_d  = CHANGE;
                    end else begin
                        credit_d = '0;
                        state_d  = IDLE;
                    end
                end
            end
            CHANGE: begin
                if (credit_q == '0) begin
                    state_d = IDLE;
                end else if (bus.chg_ack) begin
                    if (credit_q > CW'(COIN_UNIT)) begin
                        credit_d = credit_q - CW'(COIN_UNIT);
                    end else begin
                        credit_d = '0;
                        state_d  = IDLE;
                    end
                end
            end
            default: begin
                state_d  = IDLE;
                credit_d = '0;
            end
        endcase
    end

    // Outputs decoded from state or taken straight from registers.
    always_comb begin
        bus.coin_ready = accepting;
        bus.busy       = (state_q == VEND) || (state_q == CHANGE);
        bus.disp_req   = (state_q == VEND);
        bus.chg_req    = (state_q == CHANGE);
        bus.credit     = credit_q;
        bus.reject     = reject_q;
        dbg_state      = state_q;
    end

endmodule

// File: tb/tb_vend_ctrl.sv
// tb_vend_ctrl: directed bench for vend_ctrl with a transaction-level credit
// model compared on every falling edge, plus hand-computed spot checks.
// Build with VEND_TIMEOUT_EN defined to exercise the idle refund (TIMEOUT = 8).
module tb_vend_ctrl;
  import vend_pkg::*;

  localparam int PRICE = 15;
  localparam int MAXC  = 35;
`ifdef VEND_TIMEOUT_EN
  localparam int TO    = 8;
  localparam bit TO_EN = 1'b1;
`else
  localparam int TO    = 255;
  localparam bit TO_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  vend_state_t dbg_state;
  int n_checks = 0;
  int n_err = 0;

  vend_if #(.CW(6)) bus ();

  vend_ctrl #(.PRICE(PRICE), .MAX_CREDIT(MAXC), .CW(6), .TIMEOUT(TO)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // clock
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: credit in rupees plus "vending" / "paying out" flags.
  int m_credit;
  int m_idle;
  bit m_vend, m_pay, m_reject;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_credit <= 0; m_vend <= 0; m_pay <= 0; m_reject <= 0; m_idle <= 0;
    end else begin
      m_reject <= 0;
      if (m_vend) begin
        if (bus.disp_ack) begin
          m_vend   <= 0;
          m_credit <= m_credit - PRICE;
          m_pay    <= (m_credit > PRICE);
        end
      end else if (m_pay) begin
        if (bus.chg_ack) begin
          m_credit <= m_credit - 5;
          m_pay    <= (m_credit > 5);
        end
      end else if (bus.cancel && m_credit > 0) begin
        m_pay <= 1; m_idle <= 0;
      end else if (bus.coin_valid && bus.coin != 2'b11) begin
        m_idle <= 0;
        if (bus.coin == 2'b10 || m_credit + (bus.coin == 2'b01 ? 10 : 5) > MAXC)
          m_reject <= 1;
        else
          m_credit <= m_credit + (bus.coin == 2'b01 ? 10 : 5);
      end else if (bus.buy && m_credit > 0) begin
        m_idle <= 0;
        if (m_credit >= PRICE) m_vend <= 1;
      end else if (TO_EN && m_credit > 0) begin
        if (m_idle + 1 == TO) begin
          m_pay <= 1; m_idle <= 0;
        end else begin
          m_idle <= m_idle + 1;
        end
      end else begin
        m_idle <= 0;
      end
    end
  end

  // Compare DUT against the model away from the active edge.
  always @(negedge clk) begin
    if (!rst) begin
      check("m_credit", 32'(bus.credit), m_credit);
      check("m_reject", 32'(bus.reject), 32'(m_reject));
      check("m_disp_req", 32'(bus.disp_req), 32'(m_vend));
      check("m_chg_req", 32'(bus.chg_req), 32'(m_pay));
      check("m_busy", 32'(bus.busy), 32'(m_vend | m_pay));
      check("m_coin_ready", 32'(bus.coin_ready), 32'(!(m_vend | m_pay)));
    end
  end

  // driver tasks: each returns 2 time units after a rising edge
  task automatic step();
    @(posedge clk); #2;
  endtask

  task automatic coin_in(input logic [1:0] c);
    bus.coin_valid = 1'b1; bus.coin = c;
    step();
    bus.coin_valid = 1'b0; bus.coin = 2'b11;
  endtask

  task automatic do_buy();
    bus.buy = 1'b1; step(); bus.buy = 1'b0;
  endtask

  task automatic do_cancel();
    bus.cancel = 1'b1; step(); bus.cancel = 1'b0;
  endtask

  task automatic ack_disp();
    int k = 0;
    while (!bus.disp_req && k < 20) begin step(); k++; end
    check("disp_req_seen", 32'(bus.disp_req), 1);
    if (bus.disp_req) begin
      bus.disp_ack = 1'b1; step(); bus.disp_ack = 1'b0;
    end
  endtask

  // Ack every cycle chg_req is high; returns once payout ends (bounded).
  task automatic ack_change(input string nm, input int n_exp);
    int n = 0;
    for (int k = 0; k < 100; k++) begin
      bus.chg_ack = bus.chg_req;
      if (bus.chg_req) n++;
      else if (n > 0 || k > 5) break;
      step();
    end
    bus.chg_ack = 1'b0;
    check(nm, n, n_exp);
  endtask

  initial begin
    #200000;
    n_err++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    bus.coin_valid = 0; bus.coin = 2'b11; bus.buy = 0; bus.cancel = 0;
    bus.disp_ack = 0; bus.chg_ack = 0;
    repeat (3) @(posedge clk);
    #2;
    check("rst_credit", 32'(bus.credit), 0);
    check("rst_coin_ready", 32'(bus.coin_ready), 1);
    check("rst_reject", 32'(bus.reject), 0);
    check("rst_disp_req", 32'(bus.disp_req), 0);
    check("rst_chg_req", 32'(bus.chg_req), 0);
    check("rst_busy", 32'(bus.busy), 0);
    rst = 1'b0;
    step();

    // 5 + 10, buy, exact price
    coin_in(2'b00);  check("t2_credit5", 32'(bus.credit), 5);
    coin_in(2'b11);  check("t2_none", 32'(bus.credit), 5);
    coin_in(2'b01);  check("t2_credit15", 32'(bus.credit), 15);
    do_buy();        check("t2_disp_req", 32'(bus.disp_req), 1);
    check("t2_busy", 32'(bus.busy), 1);
    ack_disp();      check("t2_credit0", 32'(bus.credit), 0);
    check("t2_no_chg", 32'(bus.chg_req), 0);
    step();          check("t2_idle_ready", 32'(bus.coin_ready), 1);

    // 10 + 10, buy, one coin of change
    coin_in(2'b01); coin_in(2'b01);
    check("t3_credit20", 32'(bus.credit), 20);
    do_buy(); ack_disp();
    check("t3_credit5", 32'(bus.credit), 5);
    check("t3_chg_req", 32'(bus.chg_req), 1);
    ack_change("t3_acks", 1);
    check("t3_credit0", 32'(bus.credit), 0);

    // ceiling and bad coins
    coin_in(2'b01); coin_in(2'b01); coin_in(2'b01);
    check("t4_credit30", 32'(bus.credit), 30);
    coin_in(2'b01);  check("t4_rej10", 32'(bus.reject), 1);
    check("t4_hold30", 32'(bus.credit), 30);
    step();          check("t4_rej_pulse", 32'(bus.reject), 0);
    coin_in(2'b10);  check("t4_rej_bad", 32'(bus.reject), 1);
    check("t4_bad30", 32'(bus.credit), 30);
    coin_in(2'b00);  check("t4_credit35", 32'(bus.credit), 35);
    check("t4_no_rej", 32'(bus.reject), 0);
    coin_in(2'b00);  check("t4_rej_max", 32'(bus.reject), 1);
    check("t4_hold35", 32'(bus.credit), 35);
    do_cancel();
    ack_change("t4_acks", 7);

    // cancel and buy together: cancel wins
    coin_in(2'b00); coin_in(2'b01);
    bus.buy = 1'b1; bus.cancel = 1'b1; step(); bus.buy = 1'b0; bus.cancel = 1'b0;
    check("t5_no_disp", 32'(bus.disp_req), 0);
    check("t5_chg", 32'(bus.chg_req), 1);
    ack_change("t5_acks", 3);

    // buy below price is ignored; coin during VEND is not taken
    coin_in(2'b00); do_buy();
    check("t6_low_buy", 32'(bus.disp_req), 0);
    coin_in(2'b01); coin_in(2'b00);
    check("t6_credit20", 32'(bus.credit), 20);
    do_buy();
    bus.coin_valid = 1'b1; bus.coin = 2'b00;
    check("t6_not_ready", 32'(bus.coin_ready), 0);
    step();
    bus.coin_valid = 1'b0; bus.coin = 2'b11;
    check("t6_coin_ignored", 32'(bus.credit), 20);
    check("t6_no_rej", 32'(bus.reject), 0);
    ack_disp();
    check("t6_credit5", 32'(bus.credit), 5);
    ack_change("t6_acks", 1);

    // cancel in IDLE ignored; cancel at 20 takes four back-to-back acks
    do_cancel();
    check("t7_idle_cancel", 32'(bus.chg_req), 0);
    coin_in(2'b01); coin_in(2'b01); do_cancel();
    ack_change("t7_acks", 4);

    // asynchronous reset mid-CHANGE
    coin_in(2'b01); coin_in(2'b01); do_cancel();
    bus.chg_ack = 1'b1; step(); bus.chg_ack = 1'b0;
    check("t8_credit15", 32'(bus.credit), 15);
    #1 rst = 1'b1;
    #1;
    check("t8_rst_credit", 32'(bus.credit), 0);
    check("t8_rst_chg", 32'(bus.chg_req), 0);
    check("t8_rst_busy", 32'(bus.busy), 0);
    check("t8_rst_ready", 32'(bus.coin_ready), 1);
    step();
    rst = 1'b0;
    step();

    // idle refund / credit held
    coin_in(2'b01);
    check("t9_credit10", 32'(bus.credit), 10);
`ifdef VEND_TIMEOUT_EN
    repeat (7) step();
    check("t9_still_credit", 32'(bus.chg_req), 0);
    step();
    check("t9_timeout_chg", 32'(bus.chg_req), 1);
    ack_change("t9_acks", 2);
`else
    repeat (1000) step();
    check("t9_held", 32'(bus.credit), 10);
    check("t9_no_chg", 32'(bus.chg_req), 0);
    do_cancel();
    ack_change("t9_acks", 2);
`endif
    step();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
